// File: rtl/fn_sweep_if.sv
// Sweep engine bus: stimulus/expectation in, truth-table results out.
// The expected-table signal is called `expected` because `expect` is a reserved word.
interface fn_sweep_if #(
    parameter int N_IN = 3
) ();
    localparam int T = 1 << N_IN;

    logic            start;
    logic [T-1:0]    expected;
    logic            s;
    logic [N_IN-1:0] vec;
    logic            busy;
    logic            done;
    logic            pass;
    logic [T-1:0]    result;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] first_err;
    logic            first_err_vld;

    modport master (
        input  start, expected, s,
        output vec, busy, done, pass, result, err_cnt, first_err, first_err_vld
    );

    modport slave (
        output start, expected, s,
        input  vec, busy, done, pass, result, err_cnt, first_err, first_err_vld
    );
endinterface

// File: rtl/fn_sweep.sv
// Exhaustive clocked sweep of an N_IN-input boolean function with truth-table check.
// Build option: FN_SWEEP_FIRST_ERR_EN enables first-mismatch capture (first_err/first_err_vld).
module fn_sweep #(
    parameter int N_IN = 3,
    parameter int LAT  = 1
) (
    input logic        clk,
    input logic        rst_n,
    fn_sweep_if.master bus
);
    localparam int              T        = 1 << N_IN;
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic            start_acc;
    logic            run_vld;
    logic            samp_vld;
    logic            samp_mis;
    logic            enter_done;
    logic [N_IN-1:0] vec_q;
    logic [N_IN-1:0] samp_idx;
    logic [T-1:0]    exp_q;
    logic [T-1:0]    result_q;
    logic [N_IN:0]   err_cnt_q, err_cnt_nxt;
    logic            pass_q;
    logic [1:0]      drain_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    start_acc = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (vec_q == VEC_LAST) state_d = (LAT > 0) ? DRAIN : DONE;
            end
            DRAIN: begin
                if (drain_cnt == 2'(LAT - 1)) state_d = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    start_acc = 1'b1;
                    state_d   = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign run_vld    = (state_q == RUN);
    assign enter_done = (state_d == DONE) && (state_q != DONE);

    // Index delay line: each applied vector travels with its valid bit so the
    // sample taken LAT cycles later knows which table entry it belongs to.
    if (LAT == 0) begin : g_comb
        assign samp_vld = run_vld;
        assign samp_idx = vec_q;
    end else begin : g_pipe
        logic [LAT:1]           vld_pipe;
        logic [LAT:1][N_IN-1:0] idx_pipe;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_pipe <= '0;
                idx_pipe <= '0;
            end else begin
                vld_pipe[1] <= run_vld;
                idx_pipe[1] <= vec_q;
                for (int k = 2; k <= LAT; k++) begin
                    vld_pipe[k] <= vld_pipe[k-1];
                    idx_pipe[k] <= idx_pipe[k-1];
                end
            end
        end

        assign samp_vld = vld_pipe[LAT];
        assign samp_idx = idx_pipe[LAT];
    end

    always_comb begin
        samp_mis    = samp_vld && (bus.s != exp_q[samp_idx]);
        err_cnt_nxt = err_cnt_q + {{N_IN{1'b0}}, samp_mis};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q     <= '0;
            exp_q     <= '0;
            result_q  <= '0;
            err_cnt_q <= '0;
            pass_q    <= 1'b0;
            drain_cnt <= '0;
        end else begin
            if (start_acc) begin
                vec_q     <= '0;
                exp_q     <= bus.expected;
                result_q  <= '0;
                err_cnt_q <= '0;
                pass_q    <= 1'b0;
            end else begin
                if (run_vld && vec_q != VEC_LAST) vec_q <= vec_q + 1'b1;
                if (samp_vld) begin
                    result_q[samp_idx] <= bus.s;
                    err_cnt_q          <= err_cnt_nxt;
                end
                // Final sample lands on the same edge as the move into DONE.
                if (enter_done) pass_q <= (err_cnt_nxt == '0);
            end
            drain_cnt <= (state_q == DRAIN) ? drain_cnt + 1'b1 : 2'd0;
        end
    end

`ifdef FN_SWEEP_FIRST_ERR_EN
    logic [N_IN-1:0] first_err_q;
    logic            first_err_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_err_q     <= '0;
            first_err_vld_q <= 1'b0;
        end else if (start_acc) begin
            first_err_q     <= '0;
            first_err_vld_q <= 1'b0;
        end else if (samp_mis && !first_err_vld_q) begin
            first_err_q     <= samp_idx;
            first_err_vld_q <= 1'b1;
        end
    end

    assign bus.first_err     = first_err_q;
    assign bus.first_err_vld = first_err_vld_q;
`else
    assign bus.first_err     = '0;
    assign bus.first_err_vld = 1'b0;
`endif

    assign bus.vec     = vec_q;
    assign bus.busy    = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done    = (state_q == DONE);
    assign bus.pass    = pass_q;
    assign bus.result  = result_q;
    assign bus.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_fn_sweep.sv
// Directed bench for fn_sweep: LAT=1 instance for single sweeps, LAT=0 for back-to-back.
module tb_fn_sweep;
    localparam int N = 3;
    localparam int T = 8;
`ifdef FN_SWEEP_FIRST_ERR_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stuck = 1'b0;
    logic s1_q;
    int   tests = 0;
    int   fails = 0;

    fn_sweep_if #(.N_IN(N)) b1 ();
    fn_sweep_if #(.N_IN(N)) b0 ();

    fn_sweep #(.N_IN(N), .LAT(1)) u_lat1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    fn_sweep #(.N_IN(N), .LAT(0)) u_lat0 (.clk(clk), .rst_n(rst_n), .bus(b0));

    always #5 clk = ~clk;

    // s = (~x|~y) & ~(y|~z), {x,y,z} = vec
    function automatic logic fn(input logic [2:0] v);
        return (~v[2] | ~v[1]) & ~(v[1] | ~v[0]);
    endfunction

    // LAT=1 instance sees a function with one register stage.
    always @(posedge clk) s1_q <= stuck ? 1'b1 : fn(b1.vec);
    assign b1.s = s1_q;
    assign b0.s = fn(b0.vec);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One sweep on the LAT=1 instance; optional start poke across edge `poke`.
    task automatic sweep(input logic [7:0] exp, input int poke,
                         output int done_edge, output int n_done,
                         output bit vec_ok, output bit busy_ok);
        @(negedge clk);
        b1.expected = exp;
        b1.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b1.start  = 1'b0;
        done_edge = -1;
        n_done    = 0;
        vec_ok    = 1'b1;
        busy_ok   = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (k < T && b1.vec !== 3'(k)) vec_ok = 1'b0;
            if (b1.busy !== (k < T + 1)) busy_ok = 1'b0;
            if (k == poke - 1) begin
                b1.start    = 1'b1;
                b1.expected = ~exp;
            end
            if (k == poke) b1.start = 1'b0;
            if (b1.done === 1'b1) begin
                n_done++;
                if (done_edge < 0) done_edge = k;
            end
        end
    endtask

    initial begin
        int de, nd, dn_ok;
        bit vok, bok, d_ok;
        b1.start = 1'b0; b1.expected = '0;
        b0.start = 1'b0; b0.expected = '0;
        repeat (3) @(negedge clk);

        check("rst_vec",    b1.vec, 0);
        check("rst_busy",   {b1.busy, b1.done, b1.pass}, 0);
        check("rst_result", b1.result, 0);
        check("rst_errcnt", b1.err_cnt, 0);
        check("rst_fe",     {b1.first_err_vld, b1.first_err}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // correct table
        sweep(8'h22, -1, de, nd, vok, bok);
        check("ok_done_edge", de, 9);
        check("ok_done_cnt",  nd, 1);
        check("ok_vec_seq",   vok, 1);
        check("ok_busy",      bok, 1);
        check("ok_result",    b1.result, 8'h22);
        check("ok_pass",      b1.pass, 1);
        check("ok_errcnt",    b1.err_cnt, 0);
        check("ok_fe_vld",    b1.first_err_vld, 0);

        // single mismatch at vector 0
        sweep(8'h23, -1, de, nd, vok, bok);
        check("m0_pass",   b1.pass, 0);
        check("m0_errcnt", b1.err_cnt, 1);
        check("m0_fe",     b1.first_err, 0);
        check("m0_fe_vld", b1.first_err_vld, FE);

        // single mismatch at vector 3
        sweep(8'h2A, -1, de, nd, vok, bok);
        check("m3_result", b1.result, 8'h22);
        check("m3_errcnt", b1.err_cnt, 1);
        check("m3_fe",     b1.first_err, FE ? 3 : 0);
        check("m3_fe_vld", b1.first_err_vld, FE);

        // stuck-at-1
        stuck = 1'b1;
        sweep(8'h22, -1, de, nd, vok, bok);
        check("sa1_result", b1.result, 8'hFF);
        check("sa1_errcnt", b1.err_cnt, 6);
        check("sa1_fe",     b1.first_err, 0);
        check("sa1_fe_vld", b1.first_err_vld, FE);
        // every vector wrong: full count, no wrap
        sweep(8'h00, -1, de, nd, vok, bok);
        check("all_errcnt", b1.err_cnt, 8);
        check("all_pass",   b1.pass, 0);
        stuck = 1'b0;

        // start pulse across edge 4 while busy, expected changed with it
        sweep(8'h22, 4, de, nd, vok, bok);
        check("busy_done_edge", de, 9);
        check("busy_done_cnt",  nd, 1);
        check("busy_result",    b1.result, 8'h22);
        check("busy_pass",      b1.pass, 1);

        // reset mid-sweep at vec=5
        @(negedge clk);
        b1.expected = 8'h00;
        b1.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b1.start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_vec",    b1.vec, 5);
        check("mid_errcnt", b1.err_cnt, 1);
        check("mid_result", b1.result, 8'h02);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vec",    b1.vec, 0);
        check("arst_busy",   b1.busy, 0);
        check("arst_result", b1.result, 0);
        check("arst_errcnt", b1.err_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {b1.busy, b1.done, b1.vec}, 0);
        sweep(8'h22, -1, de, nd, vok, bok);
        check("post_rst_done",   de, 9);
        check("post_rst_result", b1.result, 8'h22);
        check("post_rst_pass",   b1.pass, 1);

        // LAT=0, start held high
        @(negedge clk);
        b0.expected = 8'h22;
        b0.start    = 1'b1;
        @(posedge clk);
        dn_ok = 0;
        vok   = 1'b1;
        d_ok  = 1'b1;
        for (int k = 0; k < 36; k++) begin
            int ph;
            @(negedge clk);
            ph = k % 9;
            if (b0.vec !== 3'((ph == 8) ? 7 : ph)) vok = 1'b0;
            if (b0.done !== (ph == 8)) d_ok = 1'b0;
            if (b0.done === 1'b1) dn_ok++;
            if (k == 17) begin
                check("b2b_result", b0.result, 8'h22);
                check("b2b_pass",   b0.pass, 1);
            end
        end
        b0.start = 1'b0;
        check("b2b_vec_seq",  vok, 1);
        check("b2b_done_pos", d_ok, 1);
        check("b2b_done_cnt", dn_ok, 4);
        repeat (3) @(negedge clk);
        check("b2b_idle", {b0.busy, b0.done}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
